// File: rtl/msk_nlfsr_pkg.sv
// Shared definitions for the masked NLFSR keystream sequencer: register width,
// sequencer state encoding and a small state-class helper.
package msk_nlfsr_pkg;

  localparam int NLFSR_W = 56;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_IV   = 3'd2,
    ST_WARM = 3'd3,
    ST_RUN  = 3'd4,
    ST_WIPE = 3'd5
  } state_e;

  // True in the states where the NLFSR may be clocked with fresh randomness.
  function automatic logic is_step_state(input state_e st);
    return (st == ST_WARM) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/msk_ks_outreg.sv
// One-bit valid/ready output register: a loaded bit is held stable until the
// consumer takes it; a clear discards it.
module msk_ks_outreg (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic bit_i,
  input  logic ready_i,
  output logic valid_o,
  output logic bit_o
);

  logic valid_q;
  logic bit_q;

  // Valid flag and data bit; the data only changes on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      bit_q   <= bit_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign bit_o   = bit_q;

endmodule

// File: rtl/msk_nlfsr_ctrl.sv
// Sequencer for the two-share masked NLFSR: seed load, serial IV, masked warm-up,
// unmasked keystream output. Define MSK_NLFSR_CTRL_WIPE_EN to zeroise on exit.
module msk_nlfsr_ctrl
  import msk_nlfsr_pkg::*;
#(
  parameter int IV_BITS = 32,
  parameter int WARMUP  = 112,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NLFSR_W-1:0] i_seed1,
  input  logic [NLFSR_W-1:0] i_seed2,
  input  logic [IV_BITS-1:0] i_iv,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [1:0]         i_rnd,
  input  logic               i_rnd_valid,
  output logic               o_rnd_ready,
  output logic               o_load,
  output logic [NLFSR_W-1:0] o_wdata1,
  output logic [NLFSR_W-1:0] o_wdata2,
  output logic               o_ser_in_valid,
  output logic               o_ser_in,
  output logic               o_halt,
  output logic               o_r1,
  output logic               o_r2,
  output logic               o_rxor,
  input  logic [NLFSR_W-1:0] i_rdata_xor,
  output logic               o_ks_valid,
  output logic               o_ks_bit,
  input  logic               i_ks_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IV_CW = $clog2(IV_BITS + 1);
  localparam int WM_CW = $clog2(WARMUP + 1);
  localparam logic [IV_CW-1:0] IV_LAST = IV_CW'(IV_BITS - 1);
  localparam logic [WM_CW-1:0] WM_LAST = WM_CW'(WARMUP - 1);

  state_e             state_q;
  logic [NLFSR_W-1:0] seed1_q, seed2_q;
  logic [IV_BITS-1:0] iv_q;
  logic [LEN_W-1:0]   len_q, gen_cnt_q;
  logic [IV_CW-1:0]   iv_cnt_q;
  logic [WM_CW-1:0]   warm_cnt_q;
  logic               load_q, ser_valid_q, rxor_q, busy_q, done_q;
`ifdef MSK_NLFSR_CTRL_WIPE_EN
  logic               wipe_done_q;
`endif

  logic abort_s, step_s, run_last_s, run_done_s, ks_load_s;
  logic ks_valid_s, ks_bit_s;
  logic unused_rdata_s;

  assign abort_s        = i_abort && (state_q != ST_IDLE);
  assign run_last_s     = (gen_cnt_q == len_q);
  assign run_done_s     = (state_q == ST_RUN) && run_last_s && (!ks_valid_s || i_ks_ready);
  assign ks_load_s      = step_s && (state_q == ST_RUN);
  assign unused_rdata_s = ^i_rdata_xor[NLFSR_W-1:1];

  // NLFSR step qualifier; in RUN it also waits for room in the output register.
  always_comb begin
    step_s = 1'b0;
    if (!is_step_state(state_q) || i_abort || !i_rnd_valid) begin
      step_s = 1'b0;
    end else begin
      case (state_q)
        ST_WARM: step_s = 1'b1;
        ST_RUN:  step_s = !run_last_s && (!ks_valid_s || i_ks_ready);
        default: step_s = 1'b0;
      endcase
    end
  end

  // Sequencer state, latched job parameters and registered NLFSR controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seed1_q     <= {NLFSR_W{1'b0}};
      seed2_q     <= {NLFSR_W{1'b0}};
      iv_q        <= {IV_BITS{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      gen_cnt_q   <= {LEN_W{1'b0}};
      iv_cnt_q    <= {IV_CW{1'b0}};
      warm_cnt_q  <= {WM_CW{1'b0}};
      load_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      rxor_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MSK_NLFSR_CTRL_WIPE_EN
      wipe_done_q <= 1'b0;
`endif
    end else begin
      load_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort_s) begin
        rxor_q <= 1'b0;
`ifdef MSK_NLFSR_CTRL_WIPE_EN
        wipe_done_q <= 1'b0;
        if (state_q == ST_WIPE) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q <= ST_WIPE;
          load_q  <= 1'b1;
          seed1_q <= {NLFSR_W{1'b0}};
          seed2_q <= {NLFSR_W{1'b0}};
          iv_q    <= {IV_BITS{1'b0}};
        end
`else
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_start) begin
              state_q    <= ST_LOAD;
              seed1_q    <= i_seed1;
              seed2_q    <= i_seed2;
              iv_q       <= i_iv;
              len_q      <= i_len;
              gen_cnt_q  <= {LEN_W{1'b0}};
              iv_cnt_q   <= {IV_CW{1'b0}};
              warm_cnt_q <= {WM_CW{1'b0}};
              load_q     <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          ST_LOAD: begin
            state_q     <= ST_IV;
            ser_valid_q <= 1'b1;
          end
          ST_IV: begin
            // IV leaves LSB first from the bottom of the shift register.
            iv_q <= iv_q >> 1;
            if (iv_cnt_q == IV_LAST) begin
              state_q <= ST_WARM;
            end else begin
              iv_cnt_q    <= iv_cnt_q + IV_CW'(1);
              ser_valid_q <= 1'b1;
            end
          end
          ST_WARM: begin
            if (step_s) begin
              if (warm_cnt_q == WM_LAST) begin
                state_q <= ST_RUN;
                rxor_q  <= 1'b1;
              end else begin
                warm_cnt_q <= warm_cnt_q + WM_CW'(1);
              end
            end
          end
          ST_RUN: begin
            if (step_s) begin
              gen_cnt_q <= gen_cnt_q + LEN_W'(1);
            end
            if (run_done_s) begin
              rxor_q <= 1'b0;
`ifdef MSK_NLFSR_CTRL_WIPE_EN
              state_q     <= ST_WIPE;
              load_q      <= 1'b1;
              seed1_q     <= {NLFSR_W{1'b0}};
              seed2_q     <= {NLFSR_W{1'b0}};
              iv_q        <= {IV_BITS{1'b0}};
              wipe_done_q <= 1'b1;
`else
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
          ST_WIPE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
`ifdef MSK_NLFSR_CTRL_WIPE_EN
            done_q      <= wipe_done_q;
            wipe_done_q <= 1'b0;
`endif
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            rxor_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  msk_ks_outreg u_outreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (abort_s),
    .load_i  (ks_load_s),
    .bit_i   (i_rdata_xor[0]),
    .ready_i (i_ks_ready),
    .valid_o (ks_valid_s),
    .bit_o   (ks_bit_s)
  );

  // Seed registers are zero while wiping, so the gated share outputs are zero then.
  assign o_load         = load_q;
  assign o_wdata1       = load_q ? seed1_q : {NLFSR_W{1'b0}};
  assign o_wdata2       = load_q ? seed2_q : {NLFSR_W{1'b0}};
  assign o_ser_in_valid = ser_valid_q;
  assign o_ser_in       = ser_valid_q & iv_q[0];
  assign o_halt         = ~step_s;
  assign o_rnd_ready    = step_s;
  assign o_r1           = step_s & i_rnd[0];
  assign o_r2           = step_s & i_rnd[1];
  assign o_rxor         = rxor_q;
  assign o_ks_valid     = ks_valid_s;
  assign o_ks_bit       = ks_bit_s;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_msk_nlfsr_ctrl.sv
// Self-checking bench for msk_nlfsr_ctrl: emulates an unmasked NLFSR from the
// controller's strobes and compares against a straight-line keystream model.
`timescale 1ns/1ps
module tb_msk_nlfsr_ctrl;

  localparam int IV_BITS = 32;
  localparam int WARMUP  = 112;
  localparam int LEN_W   = 16;
  localparam int NW      = 56;
`ifdef MSK_NLFSR_CTRL_WIPE_EN
  localparam int WIPE = 1;
`else
  localparam int WIPE = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0;
  logic [NW-1:0] i_seed1 = '0, i_seed2 = '0;
  logic [IV_BITS-1:0] i_iv = '0;
  logic [LEN_W-1:0] i_len = '0;
  logic [1:0] i_rnd = 2'b00;
  logic i_rnd_valid = 1'b1, i_ks_ready = 1'b1;
  logic [NW-1:0] i_rdata_xor;
  logic o_rnd_ready, o_load, o_ser_in_valid, o_ser_in, o_halt, o_r1, o_r2, o_rxor;
  logic o_ks_valid, o_ks_bit, o_busy, o_done;
  logic [NW-1:0] o_wdata1, o_wdata2;

  always #5 clk = ~clk;

  msk_nlfsr_ctrl #(.IV_BITS(IV_BITS), .WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_seed1(i_seed1), .i_seed2(i_seed2), .i_iv(i_iv), .i_len(i_len),
    .i_rnd(i_rnd), .i_rnd_valid(i_rnd_valid), .o_rnd_ready(o_rnd_ready),
    .o_load(o_load), .o_wdata1(o_wdata1), .o_wdata2(o_wdata2),
    .o_ser_in_valid(o_ser_in_valid), .o_ser_in(o_ser_in), .o_halt(o_halt),
    .o_r1(o_r1), .o_r2(o_r2), .o_rxor(o_rxor), .i_rdata_xor(i_rdata_xor),
    .o_ks_valid(o_ks_valid), .o_ks_bit(o_ks_bit), .i_ks_ready(i_ks_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Unmasked NLFSR: randomness cancels between shares, so steps shift in 0.
  function automatic logic [NW-1:0] nl_step(input logic [NW-1:0] s, input logic b);
    logic fb;
    fb = s[55] ^ s[33] ^ s[12] ^ (s[7] & s[41]) ^ b;
    return {s[NW-2:0], fb};
  endfunction

  logic [NW-1:0] nl_q = '0;
  assign i_rdata_xor = nl_q;

  always @(posedge clk) begin
    if (o_load) nl_q <= o_wdata1 ^ o_wdata2;
    else if (o_ser_in_valid) nl_q <= nl_step(nl_q, o_ser_in);
    else if (!o_halt) nl_q <= nl_step(nl_q, 1'b0);
  end

  // Event monitor, sampled mid-cycle.
  int n_load = 0, n_zero = 0, n_warm = 0, n_run = 0, n_done = 0, n_excl = 0, n_rnd_bad = 0;
  bit ser_q[$];
  bit ks_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_load) n_load <= n_load + 1;
      if (o_load && ((o_wdata1 | o_wdata2) == '0)) n_zero <= n_zero + 1;
      if (o_ser_in_valid) ser_q.push_back(o_ser_in);
      if (!o_halt && !o_rxor) n_warm <= n_warm + 1;
      if (!o_halt && o_rxor) n_run <= n_run + 1;
      if ((int'(o_load) + int'(o_ser_in_valid) + int'(!o_halt)) > 1) n_excl <= n_excl + 1;
      if ((o_rnd_ready !== !o_halt) || (!o_halt && !i_rnd_valid) ||
          ({o_r2, o_r1} !== (o_halt ? 2'b00 : i_rnd))) n_rnd_bad <= n_rnd_bad + 1;
      if (o_ks_valid && i_ks_ready) ks_q.push_back(o_ks_bit);
      if (o_done) n_done <= n_done + 1;
    end
  end

  int n_vec = 0, n_mis = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit exp_q[$];
  task automatic ref_model(input logic [NW-1:0] s1, input logic [NW-1:0] s2,
                           input logic [IV_BITS-1:0] iv, input int len);
    logic [NW-1:0] s;
    s = s1 ^ s2;
    for (int i = 0; i < IV_BITS; i++) s = nl_step(s, iv[i]);
    for (int i = 0; i < WARMUP; i++) s = nl_step(s, 1'b0);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(s[0]);
      s = nl_step(s, 1'b0);
    end
  endtask

  int b_load, b_zero, b_warm, b_run, b_done, b_excl, b_rnd, b_ser, b_ks;
  task automatic snap();
    b_load = n_load; b_zero = n_zero; b_warm = n_warm; b_run = n_run; b_done = n_done;
    b_excl = n_excl; b_rnd = n_rnd_bad; b_ser = ser_q.size(); b_ks = ks_q.size();
  endtask

  task automatic start_job(input logic [NW-1:0] s1, input logic [NW-1:0] s2,
                           input logic [IV_BITS-1:0] iv, input int len);
    i_seed1 = s1; i_seed2 = s2; i_iv = iv; i_len = LEN_W'(len);
    ref_model(s1, s2, iv, len);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_rand, input bit rdy_rand, output bit got);
    int start_done;
    start_done = n_done;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      i_rnd = 2'($urandom);
      i_rnd_valid = rnd_rand ? 1'($urandom) : 1'b1;
      i_ks_ready = rdy_rand ? 1'($urandom) : 1'b1;
      tick();
      if (n_done != start_done) got = 1'b1;
    end
    i_rnd_valid = 1'b0;
    i_ks_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_run(input string tag, input logic [IV_BITS-1:0] iv, input int len);
    logic [63:0] a, e;
    chk({tag, "_done_cnt"}, 64'(n_done - b_done), 64'd1);
    chk({tag, "_loads"}, 64'(n_load - b_load), 64'(1 + WIPE));
    chk({tag, "_zero_loads"}, 64'(n_zero - b_zero), 64'(WIPE));
    chk({tag, "_ser_cnt"}, 64'(ser_q.size() - b_ser), 64'(IV_BITS));
    a = '0;
    for (int i = 0; i < IV_BITS; i++)
      a[i] = (b_ser + i < ser_q.size()) ? ser_q[b_ser + i] : ~iv[i];
    chk({tag, "_ser_bits"}, a, 64'(iv));
    chk({tag, "_warm_steps"}, 64'(n_warm - b_warm), 64'(WARMUP));
    chk({tag, "_run_steps"}, 64'(n_run - b_run), 64'(len));
    chk({tag, "_ks_cnt"}, 64'(ks_q.size() - b_ks), 64'(len));
    a = '0; e = '0;
    for (int i = 0; i < len && i < 64; i++) begin
      e[i] = exp_q[i];
      a[i] = (b_ks + i < ks_q.size()) ? ks_q[b_ks + i] : ~exp_q[i];
    end
    chk({tag, "_ks_bits"}, a, e);
    chk({tag, "_excl"}, 64'(n_excl - b_excl), 64'd0);
    chk({tag, "_rnd_ctrl"}, 64'(n_rnd_bad - b_rnd), 64'd0);
    chk({tag, "_busy_end"}, 64'(o_busy), 64'd0);
  endtask

  typedef struct {
    logic [NW-1:0]      seed1;
    logic [NW-1:0]      seed2;
    logic [IV_BITS-1:0] iv;
    int                 len;
    bit                 rnd_rand;
    bit                 rdy_rand;
    int                 exp_ks;
  } vec_t;

  function automatic vec_t mk(input logic [NW-1:0] s1, input logic [NW-1:0] s2,
                              input logic [IV_BITS-1:0] iv, input int len,
                              input bit rr, input bit yr);
    vec_t v;
    v.seed1 = s1; v.seed2 = s2; v.iv = iv; v.len = len;
    v.rnd_rand = rr; v.rdy_rand = yr; v.exp_ks = len;
    return v;
  endfunction

  initial begin
    vec_t tbl[6];
    bit got, held, saw_ks;
    int done_cyc;
    logic [NW-1:0] rs1, rs2;
    logic [IV_BITS-1:0] riv;

    tbl[0] = mk(56'h1, 56'h0, 32'hA5A5A5A5, 8, 1'b0, 1'b0);
    tbl[1] = mk(56'h1, 56'h0, 32'hA5A5A5A5, 8, 1'b1, 1'b0);
    tbl[2] = mk(56'({$urandom, $urandom}), 56'h5A, 32'($urandom), 16, 1'b0, 1'b1);
    tbl[3] = mk(56'({$urandom, $urandom}), 56'({$urandom, $urandom}), 32'($urandom), 1, 1'b1, 1'b1);
    tbl[4] = mk(56'hFF_FFFF_FFFF_FFFF, 56'h12_3456_789A_BCDE, 32'h0000_0001, 37, 1'b1, 1'b1);
    tbl[5] = mk(56'({$urandom, $urandom}), 56'h80_0000_0000_0000, 32'hFFFF_FFFF, 5, 1'b0, 1'b1);

    // Reset values, with randomness offered so halt must hold on its own.
    #1;
    chk("reset_ctrl", {o_halt, o_busy, o_load, o_ser_in_valid, o_rnd_ready, o_rxor, o_ks_valid, o_done},
        {1'b1, 7'b0});
    chk("reset_wdata", 64'(o_wdata1 | o_wdata2), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i_rnd_valid = 1'b0;
    tick();

    foreach (tbl[n]) begin
      snap();
      start_job(tbl[n].seed1, tbl[n].seed2, tbl[n].iv, tbl[n].len);
      wait_done(tbl[n].rnd_rand, tbl[n].rdy_rand, got);
      chk($sformatf("vec%0d_done_seen", n), 64'(got), 64'd1);
      check_run($sformatf("vec%0d", n), tbl[n].iv, tbl[n].exp_ks);
    end

    // Load/IV timing, then five cycles of consumer backpressure mid-RUN.
    snap();
    rs1 = 56'({$urandom, $urandom});
    i_rnd_valid = 1'b1;
    start_job(rs1, 56'h0, 32'hA5A5A5A5, 12);
    chk("bp_load_cyc1", {o_load, o_ser_in_valid}, 2'b10);
    chk("bp_wdata1", 64'(o_wdata1), 64'(rs1));
    tick();
    chk("bp_ser_first", {o_ser_in_valid, o_ser_in}, 2'b11);
    for (int c = 0; c < 500 && (ks_q.size() - b_ks) < 4; c++) begin
      i_rnd = 2'($urandom);
      tick();
    end
    i_ks_ready = 1'b0;
    #1;
    held = o_ks_bit;
    for (int c = 0; c < 5; c++) begin
      i_rnd = 2'($urandom);
      #1;
      chk($sformatf("bp_valid_%0d", c), 64'(o_ks_valid), 64'd1);
      chk($sformatf("bp_bit_%0d", c), 64'(o_ks_bit), 64'(held));
      chk($sformatf("bp_rdy_%0d", c), {o_rnd_ready, o_halt}, 2'b01);
      tick();
    end
    wait_done(1'b0, 1'b0, got);
    chk("bp_done_seen", 64'(got), 64'd1);
    check_run("bp", 32'hA5A5A5A5, 12);

    // Abort while IV bit 10 is on the serial line.
    snap();
    i_rnd_valid = 1'b1;
    start_job(56'h3, 56'h1, 32'hA5A5A5A5, 4);
    repeat (11) tick();
    chk("ab_iv_bit10", {o_ser_in_valid, o_ser_in}, 2'b11);
    chk("ab_ser_cnt", 64'(ser_q.size() - b_ser), 64'd10);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("ab_next", {o_busy, o_load, o_ser_in_valid, o_ks_valid}, {WIPE[0], WIPE[0], 2'b00});
    chk("ab_wdata", 64'(o_wdata1 | o_wdata2), 64'd0);
    tick();
    chk("ab_idle", 64'(o_busy), 64'd0);
    repeat (5) tick();
    chk("ab_no_done", 64'(n_done - b_done), 64'd0);
    chk("ab_loads", 64'(n_load - b_load), 64'(1 + WIPE));
    chk("ab_zero_loads", 64'(n_zero - b_zero), 64'(WIPE));

    // len = 0 with a start attempt while busy.
    snap();
    riv = 32'($urandom);
    rs2 = 56'({$urandom, $urandom}) | 56'h1;
    i_rnd_valid = 1'b1;
    i_ks_ready = 1'b1;
    start_job(56'h0, rs2, riv, 0);
    done_cyc = -1;
    saw_ks = 1'b0;
    for (int k = 1; k <= 300 && done_cyc < 0; k++) begin
      i_rnd = 2'($urandom);
      i_start = (k == 20);
      if (k == 20) begin
        i_iv = ~riv;
        i_len = 16'd5;
      end
      #1;
      if (o_ks_valid) saw_ks = 1'b1;
      if (o_done) done_cyc = k;
      tick();
    end
    i_start = 1'b0;
    i_rnd_valid = 1'b0;
    repeat (3) tick();
    chk("len0_done_cycle", 64'(done_cyc), 64'(2 + IV_BITS + WARMUP + 1 + WIPE));
    chk("len0_no_ks", 64'(saw_ks), 64'd0);
    check_run("len0", riv, 0);

    // Asynchronous reset in the middle of RUN.
    i_rnd_valid = 1'b1;
    snap();
    start_job(56'h77, 56'h11, 32'h1234_5678, 20);
    for (int c = 0; c < 500 && !(o_rxor && (ks_q.size() - b_ks) >= 3); c++) begin
      i_rnd = 2'($urandom);
      tick();
    end
    chk("rst_in_run", {o_rxor, o_busy}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_run", {o_halt, o_ks_valid, o_busy, o_rxor, o_done}, 5'b10000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after", {o_halt, o_busy}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
